// File: rtl/dataframe_pkg.sv
// Shared definitions for the dataframe readout path: frame geometry,
// header tag and the readout sequencer state encoding.
package dataframe_pkg;

  localparam int DF_WIDTH = 234;
  localparam int DF_WORDS = 8;
  localparam logic [7:0] DF_HDR_TAG = 8'hA5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    HDR    = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } df_seq_state_t;

endpackage

// File: rtl/df_word_mux.sv
// Selects one stream word out of the captured frame register. The last
// word carries only the frame's leftover top bits, zero-extended.
module df_word_mux
  import dataframe_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAME_WIDTH = DF_WIDTH,
  parameter int WORDS       = DF_WORDS,
  parameter int IDX_W       = 3
) (
  input  logic [FRAME_WIDTH-1:0] frame,
  input  logic [IDX_W-1:0]       idx,
  output logic [DATA_WIDTH-1:0]  word
);

  localparam int LAST_W = FRAME_WIDTH - (WORDS - 1) * DATA_WIDTH;

  // Full-width slices for the leading words, zero-extended remainder last
  always_comb begin
    word = '0;
    if (idx == IDX_W'(WORDS - 1)) begin
      word[LAST_W-1:0] = frame[FRAME_WIDTH-1 -: LAST_W];
    end else begin
      for (int k = 0; k < WORDS - 1; k++) begin
        if (idx == IDX_W'(k)) word = frame[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/dataframe_readout_seq.sv
// Autonomous readout sequencer: pops frames from the FWFT dataframe FIFO
// and serialises each into 32-bit stream words for the DMA.
// Optional feature: define DF_SEQ_HEADER_EN to prepend a header word
// {A5, 00, frames_sent} to every frame.
module dataframe_readout_seq
  import dataframe_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAME_WIDTH = DF_WIDTH,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic                   ctrl_start_i,
  input  logic                   ctrl_stop_i,
  input  logic [CNT_WIDTH-1:0]   ctrl_nframes_i,
  input  logic [FRAME_WIDTH-1:0] fifo_dout_i,
  input  logic                   fifo_empty_i,
  output logic                   fifo_rd_en_o,
  output logic [DATA_WIDTH-1:0]  m_tdata_o,
  output logic                   m_tvalid_o,
  input  logic                   m_tready_i,
  output logic                   m_tlast_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CNT_WIDTH-1:0]   frames_sent_o
);

  localparam int IDX_W = $clog2(DF_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DF_WORDS - 1);

  df_seq_state_t          state, state_nxt;
  logic [FRAME_WIDTH-1:0] frame_q;
  logic [IDX_W-1:0]       word_idx;
  logic [CNT_WIDTH-1:0]   budget_q;
  logic [CNT_WIDTH-1:0]   frames_sent_q;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic                   stop_q;
  logic                   pop;
  logic                   accept_last;
  logic [DATA_WIDTH-1:0]  payload_word;

  df_word_mux #(
    .DATA_WIDTH  (DATA_WIDTH),
    .FRAME_WIDTH (FRAME_WIDTH),
    .WORDS       (DF_WORDS),
    .IDX_W       (IDX_W)
  ) u_word_mux (
    .frame (frame_q),
    .idx   (word_idx),
    .word  (payload_word)
  );

  assign cnt_inc       = (&frames_sent_q) ? frames_sent_q : frames_sent_q + CNT_WIDTH'(1);
  assign accept_last   = (state == STREAM) && m_tready_i && (word_idx == LAST_IDX);
  assign fifo_rd_en_o  = pop;
  assign busy_o        = (state != IDLE);
  assign frames_sent_o = frames_sent_q;

  // State register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= IDLE;
    else                state <= state_nxt;
  end

  // Next-state, pop strobe and stream outputs (valid depends on state only)
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    m_tvalid_o = 1'b0;
    m_tlast_o  = 1'b0;
    m_tdata_o  = '0;
    case (state)
      IDLE: begin
        if (ctrl_start_i) state_nxt = WAIT;
      end
      WAIT: begin
        // A pending or arriving stop wins over popping a new frame
        if (ctrl_stop_i || stop_q) begin
          state_nxt = IDLE;
        end else if (!fifo_empty_i) begin
          pop = 1'b1;
`ifdef DF_SEQ_HEADER_EN
          state_nxt = HDR;
`else
          state_nxt = STREAM;
`endif
        end
      end
`ifdef DF_SEQ_HEADER_EN
      HDR: begin
        m_tvalid_o = 1'b1;
        m_tdata_o  = {DF_HDR_TAG, 8'h00, frames_sent_q[15:0]};
        if (m_tready_i) state_nxt = STREAM;
      end
`endif
      STREAM: begin
        m_tvalid_o = 1'b1;
        m_tdata_o  = payload_word;
        m_tlast_o  = (word_idx == LAST_IDX);
        if (accept_last) begin
          // Budget exhaustion outranks a stop arriving on the same word
          if ((budget_q != '0) && (cnt_inc == budget_q)) state_nxt = DONE;
          else if (stop_q || ctrl_stop_i)                 state_nxt = IDLE;
          else                                            state_nxt = WAIT;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control: budget latch, frame counter, stop flag and done pulse
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      budget_q      <= '0;
      frames_sent_q <= '0;
      stop_q        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      done_o <= (state == DONE);
      if ((state == IDLE) && ctrl_start_i) begin
        budget_q      <= ctrl_nframes_i;
        frames_sent_q <= '0;
        stop_q        <= 1'b0;
      end else begin
        if (ctrl_stop_i && (state != IDLE)) stop_q <= 1'b1;
        if (accept_last)                    frames_sent_q <= cnt_inc;
      end
    end
  end

  // Frame capture on pop; word index advances on each accepted payload word
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      frame_q  <= '0;
      word_idx <= '0;
    end else if (pop) begin
      frame_q  <= fifo_dout_i;
      word_idx <= '0;
    end else if ((state == STREAM) && m_tready_i) begin
      word_idx <= word_idx + IDX_W'(1);
    end
  end

endmodule

// File: doc/dataframe_readout_seq.md
# dataframe_readout_seq

Autonomous readout sequencer for the lpGBT dataframe FIFO, living in the AXI clock domain. It pops 234-bit frames from the first-word-fall-through dataframe FIFO and serialises each one into 32-bit words on an AXI-Stream style master port feeding the DMA. This removes the need for software to read the dataframe registers one word at a time. Software starts and stops the sequencer, and can optionally set a frame budget; status goes back to the register bank.

## Interface
- `DATA_WIDTH`, 32, stream word width
- `FRAME_WIDTH`, 234, dataframe width
- `CNT_WIDTH`, 16, frame-budget and frame-counter width
- `S_AXI_ACLK` in 1: sole clock
- `S_AXI_ARESETN` in 1: reset, asynchronous assert, active-low
- `ctrl_start_i` in 1: one-cycle start pulse
- `ctrl_stop_i` in 1: one-cycle stop pulse
- `ctrl_nframes_i` in CNT_WIDTH: frame budget; 0 = unlimited; sampled on start
- `fifo_dout_i` in FRAME_WIDTH: FWFT FIFO head; valid while `fifo_empty_i`=0
- `fifo_empty_i` in 1: FIFO empty
- `fifo_rd_en_o` out 1: pop strobe, one cycle per frame
- `m_tdata_o` out DATA_WIDTH: stream data
- `m_tvalid_o` out 1: stream valid
- `m_tready_i` in 1: stream ready
- `m_tlast_o` out 1: last word of the frame
- `busy_o` out 1: sequencer not in IDLE
- `done_o` out 1: one-cycle pulse when the frame budget is exhausted
- `frames_sent_o` out CNT_WIDTH: frames fully transmitted since the last start

## Operation
- States:
  - IDLE
  - WAIT: waits for FIFO not empty
  - HDR: only with the macro
  - STREAM: emits words 0..7
  - DONE
- IDLE -> WAIT on `ctrl_start_i`.
  - Latch `ctrl_nframes_i`.
  - Clear `frames_sent_o` and the stop flag.
- Start while busy: ignored.
- WAIT, `fifo_empty_i`=0:
  - Capture `fifo_dout_i` into the frame register.
  - Assert `fifo_rd_en_o` for exactly that cycle.
  - Reset the word index to 0.
  - Go to HDR or STREAM.
- STREAM word mapping:
  - Word k = frame[32k+31:32k] for k=0..6.
  - Word 7 = {22'b0, frame[233:224]}; `m_tlast_o`=1 with word 7 only.
- Word index advances only on `m_tvalid_o` & `m_tready_i`.
- Word 7 accepted:
  - `frames_sent_o` increments, saturating at all-ones.
  - Then, in priority order:
    - budget ≠ 0 and new count == budget -> DONE.
    - stop flag set -> IDLE.
    - otherwise -> WAIT.
- DONE: `done_o`=1 for one cycle, then IDLE.
- `ctrl_stop_i`:
  - Sets the stop flag; a frame in flight always completes, never truncated.
  - In WAIT, stop exits to IDLE on the next cycle without popping.
  - Stop and budget exhaustion on the same final word -> DONE (done pulse wins).
- FIFO empty between frames: remain in WAIT, `m_tvalid_o`=0. Not an error.
- Asynchronous reset mid-frame: aborts immediately; a frame already popped is discarded.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Frame register, counters and stop flag all 0.
- Pop to first word: `fifo_rd_en_o` in cycle N; `m_tvalid_o`=1 with word 0 (or header) in cycle N+1.
- Stream handshake:
  - `m_tvalid_o` never drops before the handshake.
  - `m_tdata_o` and `m_tlast_o` are stable while `m_tvalid_o`=1 & `m_tready_i`=0.
  - `m_tvalid_o` does not depend combinationally on `m_tready_i`.
- Throughput with `m_tready_i` tied high: 9 cycles/frame (8 words + 1 WAIT/pop cycle); 10 cycles/frame with the header.
- Counter timing:
  - `frames_sent_o` updates the cycle after word 7 is accepted.
  - `done_o` pulses the cycle after that.
  - `busy_o` falls together with the return to IDLE.

## Configuration
- `DF_SEQ_HEADER_EN` defined:
  - HDR state is inserted before word 0 of every frame.
  - Header word = {8'hA5, 8'h00, frames_sent[15:0]}.
  - Frame is 9 words; `m_tlast_o` still marks word 7 of the payload.
- Undefined: HDR state and its logic are absent; the frame is 8 words.

## Structure
- Shared package `dataframe_pkg` holds:
  - `DF_WIDTH`=234
  - `DF_WORDS`=8
  - `DF_HDR_TAG`=8'hA5
  - the `df_seq_state_t` enum (IDLE, WAIT, HDR, STREAM, DONE)
- One sub-module: `df_word_mux`, combinational frame-register-plus-index -> 32-bit word with the zero-extended last word.
- FSM, counters and handshake stay in the top module.

## Test plan
- Budget 2, two frames preloaded (frame0 word k = 32'h1000_0000+k), `m_tready_i`=1:
  - 16 words, `m_tlast_o` on beats 8 and 16.
  - `fifo_rd_en_o` pulsed twice.
  - `done_o` once; `frames_sent_o`=2.
- Frame with bits [233:224]=10'h3FF: word 7 = 32'h0000_03FF.
- `m_tready_i` toggling 1/0 every cycle: data held stable while stalled; no word lost or duplicated; 16 cycles per 8 words.
- Budget 0, `ctrl_stop_i` during word 3 of frame 5:
  - Frame 5 completes; `frames_sent_o`=5.
  - IDLE with no `done_o`.
  - No further pop.
- FIFO empty after start: stays in WAIT with `m_tvalid_o`=0. Push one frame: pop, then first word exactly one cycle later.
- `S_AXI_ARESETN` low during word 4, then start again: all outputs 0, IDLE, `frames_sent_o`=0; next frame streams from word 0.
